// File: rtl/mips_dmem_responder.sv
// Wait-stated data-memory responder for a MIPS core, with a FIFO log of committed stores.
// One access is in flight at a time: IDLE latches the request, WAIT stalls, RESP strobes ready.
module mips_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned LOG_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  input  logic        log_pop,
  output logic        log_valid,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned PTR_W     = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned LOG_SLOTS = 1 << PTR_W;
  localparam int unsigned WCNT_W    = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  logic [31:0]         mem_q [DEPTH_WORDS];
  logic [31:0]         log_addr_mem_q [LOG_SLOTS];
  logic [31:0]         log_data_mem_q [LOG_SLOTS];

  logic                commit_c;
  logic [31:0]         acc_addr_c;
  logic [31:0]         acc_wdata_c;
  logic                acc_we_c;
  logic                hit_c;
  logic [IDX_W-1:0]    acc_idx_c;
  logic [31:0]         rd_word_c;
  logic                push_c;
  logic                pop_c;
  logic                full_c;
  logic                push_ok_c;

  // With zero wait states the access commits on the same edge it is requested,
  // so the committing operands come straight from the ports in IDLE.
  assign acc_addr_c  = (state_q == IDLE) ? addr     : addr_q;
  assign acc_wdata_c = (state_q == IDLE) ? wdata    : wdata_q;
  assign acc_we_c    = (state_q == IDLE) ? memwrite : we_q;
  assign hit_c       = (acc_addr_c[1:0] == 2'b00) && (acc_addr_c[31:2] < 30'(DEPTH_WORDS));
  assign acc_idx_c   = acc_addr_c[IDX_W+1:2];
  assign rd_word_c   = mem_q[acc_idx_c];

  assign push_c    = commit_c && hit_c && acc_we_c;
  assign pop_c     = log_pop && (cnt_q != '0);
  assign full_c    = (cnt_q == CNT_W'(LOG_DEPTH));
  assign push_ok_c = push_c && (!full_c || pop_c);

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = memwrite;
          if (WAIT_CYCLES == 0) begin
            state_d  = RESP;
            commit_c = 1'b1;
          end else begin
            state_d = WAIT;
            wcnt_d  = WCNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (wcnt_q >= WCNT_W'(WAIT_CYCLES)) begin
          state_d  = RESP;
          commit_c = 1'b1;
          wcnt_d   = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = commit_c;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (commit_c) begin
      err_d   = !hit_c;
      rdata_d = !hit_c ? 32'd0 : (acc_we_c ? acc_wdata_c : rd_word_c);
    end

    wr_ptr_d = push_ok_c ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_c ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
    ovf_d    = ovf_q || (push_c && full_c && !pop_c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage arrays keep their contents through reset; writes are blocked while reset is low.
  always_ff @(posedge clk) begin
    if (reset && push_c) begin
      mem_q[acc_idx_c] <= acc_wdata_c;
    end
    if (reset && push_ok_c) begin
      log_addr_mem_q[wr_ptr_q] <= acc_addr_c;
      log_data_mem_q[wr_ptr_q] <= acc_wdata_c;
    end
  end

  assign ready        = ready_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign log_valid    = (cnt_q != '0);
  assign log_addr     = log_valid ? log_addr_mem_q[rd_ptr_q] : 32'd0;
  assign log_data     = log_valid ? log_data_mem_q[rd_ptr_q] : 32'd0;
  assign log_overflow = ovf_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for mips_dmem_responder: directed accesses push expected responses,
// a negedge monitor pops and compares them whenever ready is seen.
module tb_mips_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        log_pop = 1'b0;
  logic        log_valid;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  mips_dmem_responder #(
    .DEPTH_WORDS(64),
    .WAIT_CYCLES(1),
    .LOG_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .memwrite    (memwrite),
    .addr        (addr),
    .wdata       (wdata),
    .ready       (ready),
    .rdata       (rdata),
    .err         (err),
    .log_pop     (log_pop),
    .log_valid   (log_valid),
    .log_addr    (log_addr),
    .log_data    (log_data),
    .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (reset && ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got ready=1 expected no response pending");
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", rdata, e.rdata);
        chk("resp_err", 32'(err), 32'(e.err));
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, input bit pop_commit);
    int lat;
    bit seen;
    exp_t e;
    @(negedge clk);
    req      = 1'b1;
    memwrite = we;
    addr     = a;
    wdata    = d;
    e.rdata  = exp_rd;
    e.err    = exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req  = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      log_pop = pop_commit && (lat == 1);
      if (ready) begin
        seen = 1'b1;
        break;
      end
    end
    log_pop = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no ready expected ready after 2 cycles (addr=0x%08h)", a);
      if (sb.size() != 0) void'(sb.pop_back());
    end else begin
      chk("ready_latency", 32'(lat), 32'd2);
    end
    @(negedge clk);
    chk("ready_one_cycle", 32'(ready), 32'd0);
  endtask

  task automatic pop_log();
    @(negedge clk);
    log_pop = 1'b1;
    @(posedge clk);
    #1;
    log_pop = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    chk({name, "_valid"}, 32'(log_valid), 32'd1);
    chk({name, "_addr"}, log_addr, a);
    chk({name, "_data"}, log_data, d);
  endtask

  task automatic chk_empty(input string name);
    @(negedge clk);
    chk({name, "_valid"}, 32'(log_valid), 32'd0);
    chk({name, "_addr"}, log_addr, 32'd0);
    chk({name, "_data"}, log_data, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_log_valid", 32'(log_valid), 32'd0);
    chk("rst_log_addr", log_addr, 32'd0);
    chk("rst_log_data", log_data, 32'd0);
    chk("rst_overflow", 32'(log_overflow), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    int ready_seen;

    // Power-on reset
    repeat (2) @(negedge clk);
    do_reset();

    // Basic store and read-back
    access(1'b1, 32'h54, 32'd5, 32'd5, 1'b0, 1'b0);
    chk_head("log_after_store", 32'h54, 32'd5);
    access(1'b0, 32'h54, 32'd0, 32'd5, 1'b0, 1'b0);

    // Rejected accesses: misaligned and out of range
    access(1'b1, 32'h56, 32'd7, 32'd0, 1'b1, 1'b0);
    access(1'b1, 32'h100, 32'd8, 32'd0, 1'b1, 1'b0);
    access(1'b0, 32'h101, 32'd0, 32'd0, 1'b1, 1'b0);
    chk_head("log_no_push_on_err", 32'h54, 32'd5);
    access(1'b0, 32'h54, 32'd0, 32'd5, 1'b0, 1'b0);
    pop_log();
    chk_empty("log_drained");
    pop_log();
    chk_empty("log_pop_when_empty");

    // Fill log past depth
    for (int v = 1; v <= 5; v++) begin
      access(1'b1, 32'((v - 1) * 4), 32'(v), 32'(v), 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("overflow_set", 32'(log_overflow), 32'd1);
    chk_head("ovf_head0", 32'h0, 32'd1);
    pop_log();
    chk_head("ovf_head1", 32'h4, 32'd2);
    pop_log();
    chk_head("ovf_head2", 32'h8, 32'd3);
    pop_log();
    chk_head("ovf_head3", 32'hC, 32'd4);
    pop_log();
    chk_empty("ovf_drained");
    chk("overflow_sticky", 32'(log_overflow), 32'd1);
    access(1'b0, 32'h10, 32'd0, 32'd5, 1'b0, 1'b0);

    // Reset clears log state but not memory
    do_reset();
    access(1'b0, 32'h54, 32'd0, 32'd5, 1'b0, 1'b0);
    access(1'b0, 32'h8, 32'd0, 32'd3, 1'b0, 1'b0);

    // Full log with push and pop on the same edge
    for (int v = 0; v < 4; v++) begin
      access(1'b1, 32'h20 + 32'(v * 4), 32'h11 + 32'(v), 32'h11 + 32'(v), 1'b0, 1'b0);
    end
    chk_head("full_head", 32'h20, 32'h11);
    access(1'b1, 32'h30, 32'h15, 32'h15, 1'b0, 1'b1);
    @(negedge clk);
    chk("push_pop_full_no_ovf", 32'(log_overflow), 32'd0);
    chk_head("pp_head1", 32'h24, 32'h12);
    pop_log();
    chk_head("pp_head2", 32'h28, 32'h13);
    pop_log();
    chk_head("pp_head3", 32'h2C, 32'h14);
    pop_log();
    chk_head("pp_tail", 32'h30, 32'h15);
    pop_log();
    chk_empty("pp_drained");

    // Reset while a store waits: the store must be aborted
    @(negedge clk);
    req      = 1'b1;
    memwrite = 1'b1;
    addr     = 32'h8;
    wdata    = 32'd9;
    @(posedge clk);
    #1;
    req = 1'b0;
    #2;
    reset = 1'b0;
    ready_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (ready) ready_seen++;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ready) ready_seen++;
    end
    chk("abort_no_ready", 32'(ready_seen), 32'd0);
    chk("abort_log_valid", 32'(log_valid), 32'd0);
    chk("abort_overflow", 32'(log_overflow), 32'd0);
    access(1'b0, 32'h8, 32'd0, 32'd3, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_dmem_responder.md
MIPS_DMEM_RESPONDER -- requirements
Module: mips_dmem_responder

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- DEPTH_WORDS, 64, number of 32-bit words in the store.
- WAIT_CYCLES, 1, wait states inserted per access (0..15).
- LOG_DEPTH, 4, entries in the store-log FIFO (power of 2).

REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-low (0 = reset).
- req, in, 1, CPU access request.
- memwrite, in, 1, 1 = store, 0 = load.
- addr, in, 32, byte address (CPU ALU result).
- wdata, in, 32, store data (CPU register rd2).
- ready, out, 1, one-cycle access-complete strobe.
- rdata, out, 32, load data.
- err, out, 1, access rejected; valid with ready.
- log_pop, in, 1, consume the log head entry.
- log_valid, out, 1, log not empty.
- log_addr, out, 32, head entry address.
- log_data, out, 32, head entry data.
- log_overflow, out, 1, sticky: a store was dropped from the log.

Function
REQ-003 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-004 IDLE transitions on req=1:
- addr, wdata and memwrite latched at that edge (edge N).
- Next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-005 WAIT SHALL count WAIT_CYCLES cycles, then go to RESP; req, addr, wdata and memwrite are ignored while in WAIT.
REQ-006 ready SHALL be 1 for exactly one cycle, the cycle after edge N+WAIT_CYCLES (RESP); RESP always returns to IDLE on the next edge.
REQ-007 Throughput SHALL be one access per WAIT_CYCLES+2 cycles; req held high re-issues an access each time the FSM is in IDLE.
REQ-008 An access SHALL be rejected (err=1 with ready, no write, no log push, rdata=0) when either condition holds:
- addr[1:0] != 0;
- addr[31:2] >= DEPTH_WORDS.
REQ-009 A valid store SHALL do all of the following at edge N+WAIT_CYCLES:
- write wdata to word addr[31:2];
- set rdata=wdata;
- push (addr, wdata) into the log.
REQ-010 A valid load SHALL register the word at addr[31:2] into rdata at edge N+WAIT_CYCLES; a store committed earlier is visible to any later load (no stale read).
REQ-011 rdata and err SHALL hold their values until the next RESP.
REQ-012 The log SHALL be a FIFO of depth LOG_DEPTH; log_addr and log_data show the head entry and are 0 when empty.
REQ-013 log_pop with log_valid=1 SHALL remove the head entry; log_pop when empty is ignored.
REQ-014 Push when full SHALL drop the new entry and set log_overflow; push and pop on the same edge when full SHALL both succeed with no overflow.
REQ-015 log_overflow SHALL clear only on reset.

Reset
REQ-016 reset=0 SHALL asynchronously force:
- state=IDLE, wait counter=0;
- ready=0, err=0, rdata=0;
- log emptied (log_valid=0, log_addr=0, log_data=0), log_overflow=0.
REQ-017 Reset asserted in WAIT or RESP SHALL abort the access: a store not yet committed is not written and not logged.
REQ-018 Memory array contents SHALL NOT be cleared by reset.
REQ-019 The first req SHALL be sampled at the first rising edge with reset=1.

Verification
REQ-020 The bench SHALL cover, with WAIT_CYCLES=1:
- Store addr=0x54, wdata=5 -> ready 2 cycles after the sampling edge; err=0, rdata=5; log_valid=1, log_addr=0x54, log_data=5.
- Load addr=0x54 immediately after that store -> rdata=5, err=0.
- Store addr=0x56 and store addr=0x100 (word 64) -> each gives ready=1 with err=1; no log push; loads of word 0x54 still return 5.
- 5 stores of values 1..5 to 0x0..0x10 with no pop -> log holds 1..4, log_overflow=1; 4 pops -> log_valid=0; log_overflow stays 1.
- Log full, then a store commits on the same edge as log_pop -> no overflow; head advances; the new entry becomes the tail.
- reset=0 while in WAIT during a store of 9 to 0x8 -> ready never asserts, log empty; a subsequent load of 0x8 returns its pre-reset value.
